// File: rtl/equiv_pkg.sv
// ============================================================================
// Module      : equiv_pkg
// Description : Shared FSM state encoding and default sizing for equiv_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package equiv_pkg;

    localparam int unsigned DEF_WIDTH  = 91;
    localparam int unsigned DEF_CNT_W  = 32;
    localparam int unsigned DEF_SETTLE = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_REPORT = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/equiv_sat_cnt.sv
// ============================================================================
// Module      : equiv_sat_cnt
// Description : Up-counter with synchronous clear and enable; holds at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module equiv_sat_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // Clear wins over enable so a new run always starts from zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

`default_nettype wire

// File: rtl/equiv_monitor.sv
// ============================================================================
// Module      : equiv_monitor
// Description : Compares two design-copy outputs per cycle over a start/stop
//               run and reports counts plus the first mismatch via valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module equiv_monitor
    import equiv_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned CNT_W  = DEF_CNT_W,
    parameter int unsigned SETTLE = DEF_SETTLE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] y_1,
    input  logic [WIDTH-1:0] y_2,
    output logic             busy,
    output logic             fail,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] mism_cnt,
    output logic [CNT_W-1:0] first_cyc,
    output logic [WIDTH-1:0] first_diff,
    output logic             rpt_valid,
    input  logic             rpt_ready
);

    localparam logic [7:0] C_SETTLE_LAST = (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);

    state_t             state_q;
    logic [7:0]         settle_q;
    logic               busy_q;
    logic               rpt_valid_q;
    logic               fail_q;
    logic [CNT_W-1:0]   first_cyc_q;
    logic [WIDTH-1:0]   first_diff_q;

    logic [WIDTH-1:0]   w_diff;
    logic               w_mism;
    logic               w_clr;
    logic               w_run;
    logic [CNT_W-1:0]   w_cycle_cnt;
    logic [CNT_W-1:0]   w_mism_cnt;

    assign w_diff = y_1 ^ y_2;
    assign w_mism = |w_diff;
    assign w_clr  = (state_q == ST_IDLE) && start;
    assign w_run  = (state_q == ST_RUN);

    equiv_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (w_clr),
        .en_i  (w_run),
        .cnt_o (w_cycle_cnt)
    );

    equiv_sat_cnt #(.W(CNT_W)) u_mism_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (w_clr),
        .en_i  (w_run && w_mism),
        .cnt_o (w_mism_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            settle_q     <= '0;
            busy_q       <= 1'b0;
            rpt_valid_q  <= 1'b0;
            fail_q       <= 1'b0;
            first_cyc_q  <= '0;
            first_diff_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        fail_q       <= 1'b0;
                        first_cyc_q  <= '0;
                        first_diff_q <= '0;
                        settle_q     <= '0;
                        busy_q       <= 1'b1;
                        state_q      <= (SETTLE == 0) ? ST_RUN : ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (stop) begin
                        busy_q      <= 1'b0;
                        rpt_valid_q <= 1'b1;
                        state_q     <= ST_REPORT;
                    end else if (settle_q == C_SETTLE_LAST) begin
                        state_q <= ST_RUN;
                    end else begin
                        settle_q <= settle_q + 8'd1;
                    end
                end
                ST_RUN: begin
                    // Capture uses the pre-increment count, i.e. the index of this compared cycle.
                    if (w_mism) begin
                        fail_q <= 1'b1;
                        if (!fail_q) begin
                            first_cyc_q  <= w_cycle_cnt;
                            first_diff_q <= w_diff;
                        end
                    end
                    if (stop) begin
                        busy_q      <= 1'b0;
                        rpt_valid_q <= 1'b1;
                        state_q     <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (rpt_ready) begin
                        rpt_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    busy_q      <= 1'b0;
                    rpt_valid_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign fail       = fail_q;
    assign cycle_cnt  = w_cycle_cnt;
    assign mism_cnt   = w_mism_cnt;
    assign first_cyc  = first_cyc_q;
    assign first_diff = first_diff_q;
    assign rpt_valid  = rpt_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_equiv_monitor.sv
// ============================================================================
// Module      : tb_equiv_monitor
// Description : Self-checking bench for equiv_monitor (table runs + corner cases).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_equiv_monitor;

    localparam int W  = 91;
    localparam int CW = 32;
    localparam int CB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic          start_a, stop_a, rdy_a;
    logic [W-1:0]  y1_a, y2_a;
    logic          busy_a, fail_a, rv_a;
    logic [CW-1:0] cc_a, mc_a, fc_a;
    logic [W-1:0]  fd_a;

    logic          start_b, stop_b, rdy_b;
    logic [W-1:0]  y1_b, y2_b;
    logic          busy_b, fail_b, rv_b;
    logic [CB-1:0] cc_b, mc_b, fc_b;
    logic [W-1:0]  fd_b;

    equiv_monitor #(.WIDTH(W), .CNT_W(CW), .SETTLE(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a),
        .y_1(y1_a), .y_2(y2_a), .busy(busy_a), .fail(fail_a),
        .cycle_cnt(cc_a), .mism_cnt(mc_a), .first_cyc(fc_a), .first_diff(fd_a),
        .rpt_valid(rv_a), .rpt_ready(rdy_a)
    );

    equiv_monitor #(.WIDTH(W), .CNT_W(CB), .SETTLE(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b),
        .y_1(y1_b), .y_2(y2_b), .busy(busy_b), .fail(fail_b),
        .cycle_cnt(cc_b), .mism_cnt(mc_b), .first_cyc(fc_b), .first_diff(fd_b),
        .rpt_valid(rv_b), .rpt_ready(rdy_b)
    );

    typedef struct {
        int            n;
        int            ma;
        int            mb;
        logic [W-1:0]  da;
        logic [W-1:0]  db;
        logic [CW-1:0] e_cyc;
        logic [CW-1:0] e_mism;
        logic          e_fail;
        logic [CW-1:0] e_fc;
        logic [W-1:0]  e_fd;
    } vec_t;

    typedef struct {
        logic [CW-1:0] cyc;
        logic [CW-1:0] mism;
        logic          fail;
        logic [CW-1:0] fc;
        logic [W-1:0]  fd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    task automatic push_exp(input logic [CW-1:0] cyc, input logic [CW-1:0] mism,
                            input logic fl, input logic [CW-1:0] fc, input logic [W-1:0] fd);
        exp_t e;
        e.cyc = cyc; e.mism = mism; e.fail = fl; e.fc = fc; e.fd = fd;
        sb.push_back(e);
    endtask

    // start, two settle cycles, then n RUN cycles with stop on the last one
    task automatic run_a(input int n, input int ma, input int mb,
                         input logic [W-1:0] da, input logic [W-1:0] db, input logic ss);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check("busy_after_start", 128'(busy_a), 128'(1));
        tick();
        tick();
        for (int i = 0; i < n; i++) begin
            y1_a    = rnd();
            y2_a    = y1_a ^ ((i == ma) ? da : ((i == mb) ? db : '0));
            stop_a  = (i == n - 1);
            start_a = ss && (i == n - 1);
            tick();
        end
        stop_a  = 1'b0;
        start_a = 1'b0;
        y2_a    = y1_a;
    endtask

    task automatic collect_a(input string tag);
        exp_t e;
        int   k;
        k = 0;
        while (rv_a !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        check({tag, ".rpt_valid"}, 128'(rv_a), 128'(1));
        check({tag, ".busy"}, 128'(busy_a), 128'(0));
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, ".cycle_cnt"},  128'(cc_a),   128'(e.cyc));
            check({tag, ".mism_cnt"},   128'(mc_a),   128'(e.mism));
            check({tag, ".fail"},       128'(fail_a), 128'(e.fail));
            check({tag, ".first_cyc"},  128'(fc_a),   128'(e.fc));
            check({tag, ".first_diff"}, 128'(fd_a),   128'(e.fd));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t         tbl[5];
        logic [W-1:0] one, top, ones, hi8;

        one  = '0; one[0] = 1'b1;
        top  = '0; top[W-1] = 1'b1;
        ones = '1;
        hi8  = {{(W-8){1'b0}}, 8'hF0};

        tbl[0] = '{100, -1, -1, '0,   '0,  32'd100, 32'd0, 1'b0, 32'd0, '0};
        tbl[1] = '{20,   7, -1, one,  '0,  32'd20,  32'd1, 1'b1, 32'd7, one};
        tbl[2] = '{15,   3,  9, one,  hi8, 32'd15,  32'd2, 1'b1, 32'd3, one};
        tbl[3] = '{10,   0, -1, top,  '0,  32'd10,  32'd1, 1'b1, 32'd0, top};
        tbl[4] = '{1,    0, -1, ones, '0,  32'd1,   32'd1, 1'b1, 32'd0, ones};

        rst_n = 1'b0;
        start_a = 1'b0; stop_a = 1'b0; rdy_a = 1'b0; y1_a = '0; y2_a = '0;
        start_b = 1'b0; stop_b = 1'b0; rdy_b = 1'b0; y1_b = '0; y2_b = '0;
        tick();
        tick();
        check("rst.busy",       128'(busy_a), 128'(0));
        check("rst.fail",       128'(fail_a), 128'(0));
        check("rst.rpt_valid",  128'(rv_a),   128'(0));
        check("rst.cycle_cnt",  128'(cc_a),   128'(0));
        check("rst.mism_cnt",   128'(mc_a),   128'(0));
        check("rst.first_cyc",  128'(fc_a),   128'(0));
        check("rst.first_diff", 128'(fd_a),   128'(0));
        check("rst.b_cycle",    128'(cc_b),   128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // stop while idle must be ignored
        stop_a = 1'b1;
        tick();
        stop_a = 1'b0;
        tick();
        check("idle_stop.busy",      128'(busy_a), 128'(0));
        check("idle_stop.rpt_valid", 128'(rv_a),   128'(0));

        rdy_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_exp(tbl[i].e_cyc, tbl[i].e_mism, tbl[i].e_fail, tbl[i].e_fc, tbl[i].e_fd);
            run_a(tbl[i].n, tbl[i].ma, tbl[i].mb, tbl[i].da, tbl[i].db, 1'b0);
            collect_a($sformatf("vec%0d", i));
            tick();
            check($sformatf("vec%0d.valid_one_cycle", i), 128'(rv_a), 128'(0));
            check($sformatf("vec%0d.hold_cycle_cnt", i),  128'(cc_a), 128'(tbl[i].e_cyc));
            check($sformatf("vec%0d.hold_first_diff", i), 128'(fd_a), 128'(tbl[i].e_fd));
        end

        // stop during SETTLE: report with cleared results
        rdy_a = 1'b0;
        push_exp(32'd0, 32'd0, 1'b0, 32'd0, '0);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        stop_a  = 1'b1;
        tick();
        stop_a = 1'b0;
        collect_a("settle_stop");
        rdy_a = 1'b1;
        tick();
        check("settle_stop.accepted", 128'(rv_a), 128'(0));

        // backpressure, with start ignored alongside stop and during REPORT
        rdy_a = 1'b0;
        push_exp(32'd5, 32'd1, 1'b1, 32'd0, one);
        run_a(5, 0, -1, one, '0, 1'b1);
        collect_a("bp");
        start_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("bp%0d.rpt_valid", i), 128'(rv_a), 128'(1));
            check($sformatf("bp%0d.cycle_cnt", i), 128'(cc_a), 128'(5));
            check($sformatf("bp%0d.first_diff", i), 128'(fd_a), 128'(one));
        end
        start_a = 1'b0;
        rdy_a   = 1'b1;
        tick();
        check("bp.accepted",      128'(rv_a),   128'(0));
        check("bp.no_rearm_busy", 128'(busy_a), 128'(0));

        // saturation on the 4-bit, zero-settle instance
        rdy_b   = 1'b0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        check("sat.busy", 128'(busy_b), 128'(1));
        for (int i = 0; i < 20; i++) begin
            y1_b   = rnd();
            y2_b   = ~y1_b;
            stop_b = (i == 19);
            tick();
        end
        stop_b = 1'b0;
        check("sat.rpt_valid",  128'(rv_b),   128'(1));
        check("sat.cycle_cnt",  128'(cc_b),   128'(15));
        check("sat.mism_cnt",   128'(mc_b),   128'(15));
        check("sat.fail",       128'(fail_b), 128'(1));
        check("sat.first_cyc",  128'(fc_b),   128'(0));
        check("sat.first_diff", 128'(fd_b),   128'(ones));
        rdy_b = 1'b1;
        tick();
        check("sat.accepted", 128'(rv_b), 128'(0));

        // asynchronous reset in the middle of RUN
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 6; i++) begin
            y1_a = rnd();
            y2_a = (i == 2) ? ~y1_a : y1_a;
            tick();
        end
        check("pre_rst.fail", 128'(fail_a), 128'(1));
        rst_n = 1'b0;
        #1;
        check("arst.busy",       128'(busy_a), 128'(0));
        check("arst.fail",       128'(fail_a), 128'(0));
        check("arst.rpt_valid",  128'(rv_a),   128'(0));
        check("arst.cycle_cnt",  128'(cc_a),   128'(0));
        check("arst.mism_cnt",   128'(mc_a),   128'(0));
        check("arst.first_cyc",  128'(fc_a),   128'(0));
        check("arst.first_diff", 128'(fd_a),   128'(0));
        @(negedge clk);
        rst_n  = 1'b1;
        stop_a = 1'b1;
        tick();
        stop_a = 1'b0;
        tick();
        check("post_rst.busy",      128'(busy_a), 128'(0));
        check("post_rst.rpt_valid", 128'(rv_a),   128'(0));

        push_exp(32'd3, 32'd0, 1'b0, 32'd0, '0);
        run_a(3, -1, -1, '0, '0, 1'b0);
        collect_a("post_rst_run");
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
